sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
Single owner of the SDRAM command/address/data pins.
- Sequences power-up init, then grants the bus to auto-refresh, write or read sub-controllers one at a time.
- Sits between SDRAM_INIT / SDRAM_AREF / write / read modules and the pad-level SDRAM interface, in the clk_100 domain.
- Refresh is never starved. A granted requester keeps the bus until it pulses its end flag.

Parameters:
ADDR_W, 13, SDRAM row/col address width
BA_W, 2, bank address width
DATA_W, 16, SDRAM data width
CMD_NOP, 4'b0111, {cs_n,ras_n,cas_n,we_n} for NOP, driven whenever no module owns the bus

Ports:
clk_100  in  1  system clock, 100 MHz; all logic on rising edge
rst_n_lock  in  1  reset, asynchronous, active-low (rst_n & PLL locked)
init_cmd  in  4  init command
init_ba  in  BA_W  init bank
init_addr  in  ADDR_W  init address
init_end  in  1  level, high once init completes
aref_req  in  1  refresh request (level, held until serviced)
aref_end  in  1  one-cycle pulse, refresh finished
aref_cmd  in  4  refresh command
aref_ba  in  BA_W  refresh bank
aref_addr  in  ADDR_W  refresh address
aref_en  out  1  refresh grant
wr_req  in  1  write request (level)
wr_end  in  1  one-cycle pulse, write burst finished
wr_cmd  in  4  write command
wr_ba  in  BA_W  write bank
wr_addr  in  ADDR_W  write address
wr_sdram_en  in  1  write module drives DQ
wr_sdram_data  in  DATA_W  write data
wr_en  out  1  write grant
rd_req  in  1  read request (level)
rd_end  in  1  one-cycle pulse, read burst finished
rd_cmd  in  4  read command
rd_ba  in  BA_W  read bank
rd_addr  in  ADDR_W  read address
rd_en  out  1  read grant
rd_sdram_data  out  DATA_W  sdram_dq sampled straight through (combinational)
sdram_cke  out  1  clock enable, constant 1
sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  command pins
sdram_ba  out  BA_W  bank pins
sdram_addr  out  ADDR_W  address pins
sdram_dq  inout  DATA_W  data pins

Behaviour:
- One-hot/encoded state register, states INIT, ARBIT, AREF, WRITE, READ. Reset value: INIT.
- INIT → ARBIT on the first clock with init_end=1. wr_req, rd_req and aref_req are ignored in INIT.
- ARBIT transitions are decided on a single clock, with priority aref_req > wr_req > rd_req:
  - aref_req=1 → AREF
  - else wr_req=1 → WRITE
  - else rd_req=1 → READ
  - else stay in ARBIT
- AREF → ARBIT on aref_end. WRITE → ARBIT on wr_end. READ → ARBIT on rd_end.
- End pulses arriving in any other state are ignored.
- No preemption: aref_req raised during WRITE/READ waits until the owner's end pulse. Owners observe aref_req themselves and terminate early.
- Minimum one ARBIT cycle between grants. Back-to-back grants have a 1-cycle bubble of NOP.
- Grants are registered decodes of the state register:
  - aref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ).
  - Each grant rises the cycle after the ARBIT decision and falls the cycle after the end pulse.
  - All grants are 0 at reset. At most one grant is high at any time.
- Command mux is combinational on state:
  - INIT → init_*, AREF → aref_*, WRITE → wr_*, READ → rd_*.
  - ARBIT → cmd=CMD_NOP, ba={BA_W{1}}, addr={ADDR_W{1}}.
- {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n} = selected cmd.
- sdram_dq = wr_sdram_data when (state==WRITE && wr_sdram_en), else high-Z. Never driven outside WRITE.
- Reset asserted mid-operation: state→INIT and grants→0 immediately (async). Pins follow init_* thereafter.

Optional Feature:
Macro SDRAM_ARB_RR_EN.
- Defined: a 1-bit last_rw flag, reset 0, is set to 1 on entering WRITE and cleared on entering READ. In ARBIT with wr_req=rd_req=1 and no aref_req, the requester that did not go last wins. Refresh stays highest priority.
- Undefined: fixed write > read priority and no last_rw flag.

Test Plan:
1. Reset, init_end rises at cycle 20001 → state ARBIT next clock. Pins show NOP (cs/ras/cas/we = 0,1,1,1), addr=13'h1FFF, ba=2'b11. All grants 0.
2. After init, aref_req=wr_req=rd_req=1 same cycle → aref_en=1 next clock, wr_en=rd_en=0. Pins mirror aref_cmd. aref_end pulse → aref_en=0 next clock, then wr_en=1 one cycle later.
3. WRITE owned, aref_req rises mid-burst → wr_en stays 1 until wr_end. Then 1 NOP cycle, then aref_en=1. DQ drives 16'hA5A5 only while wr_sdram_en=1, Z otherwise.
4. wr_req and rd_req held continuously, no refresh. Without SDRAM_ARB_RR_EN, only wr_en is ever granted. With SDRAM_ARB_RR_EN, grants alternate W,R,W,R.
5. rst_n_lock pulled low during READ → rd_en=0 and state INIT without clock edge. rd_end/wr_req then ignored until init_end=1.
6. Throughout, an assertion checks aref_en+wr_en+rd_en ≤ 1, and sdram_dq is Z whenever wr_en=0.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM arbiter, its init/refresh/write/read sub-controllers and the pads.
// sdram_dq is not carried here; it stays a plain inout on the arbiter so tristate resolution is simple.
interface sdram_arbiter_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned BA_W   = 2,
    parameter int unsigned DATA_W = 16
);
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;

    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_en;

    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    logic              wr_en;

    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_sdram_data;

    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;

    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output aref_en,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        output wr_en,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output rd_en, rd_sdram_data,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
    );

    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  aref_en,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        input  wr_en,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  rd_en, rd_sdram_data,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Sole owner of the SDRAM pins: runs init, then grants refresh > write > read one at a time.
// Define SDRAM_ARB_RR_EN to alternate write/read when both request together.
module sdram_arbiter #(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned BA_W    = 2,
    parameter int unsigned DATA_W  = 16,
    parameter logic [3:0]  CMD_NOP = 4'b0111
) (
    input  logic              clk_100,
    input  logic              rst_n_lock,
    sdram_arbiter_if.slave    bus,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    typedef enum logic [2:0] {StInit, StArbit, StAref, StWrite, StRead} state_e;

    state_e            r_state;
    state_e            w_next_state;
    logic              r_aref_en;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              w_pick_wr;
    logic [3:0]        w_cmd;
    logic [BA_W-1:0]   w_ba;
    logic [ADDR_W-1:0] w_addr;

`ifdef SDRAM_ARB_RR_EN
    // 1: write was granted last, 0: read was (or nothing yet)
    logic r_last_rw;

    assign w_pick_wr = bus.wr_req && !(bus.rd_req && r_last_rw);

    always_ff @(posedge clk_100 or negedge rst_n_lock) begin
        if (!rst_n_lock) begin
            r_last_rw <= 1'b0;
        end else if (r_state == StArbit && w_next_state == StWrite) begin
            r_last_rw <= 1'b1;
        end else if (r_state == StArbit && w_next_state == StRead) begin
            r_last_rw <= 1'b0;
        end
    end
`else
    assign w_pick_wr = bus.wr_req;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StInit:  if (bus.init_end) w_next_state = StArbit;
            StArbit: begin
                if (bus.aref_req)    w_next_state = StAref;
                else if (w_pick_wr)  w_next_state = StWrite;
                else if (bus.rd_req) w_next_state = StRead;
            end
            StAref:  if (bus.aref_end) w_next_state = StArbit;
            StWrite: if (bus.wr_end)   w_next_state = StArbit;
            StRead:  if (bus.rd_end)   w_next_state = StArbit;
            default: w_next_state = StInit;
        endcase
    end

    // Grants are flopped from next state so they line up exactly with r_state.
    always_ff @(posedge clk_100 or negedge rst_n_lock) begin
        if (!rst_n_lock) begin
            r_state   <= StInit;
            r_aref_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_aref_en <= (w_next_state == StAref);
            r_wr_en   <= (w_next_state == StWrite);
            r_rd_en   <= (w_next_state == StRead);
        end
    end

    always_comb begin
        w_cmd  = CMD_NOP;
        w_ba   = {BA_W{1'b1}};
        w_addr = {ADDR_W{1'b1}};
        case (r_state)
            StInit: begin
                w_cmd  = bus.init_cmd;
                w_ba   = bus.init_ba;
                w_addr = bus.init_addr;
            end
            StAref: begin
                w_cmd  = bus.aref_cmd;
                w_ba   = bus.aref_ba;
                w_addr = bus.aref_addr;
            end
            StWrite: begin
                w_cmd  = bus.wr_cmd;
                w_ba   = bus.wr_ba;
                w_addr = bus.wr_addr;
            end
            StRead: begin
                w_cmd  = bus.rd_cmd;
                w_ba   = bus.rd_ba;
                w_addr = bus.rd_addr;
            end
            default: ;
        endcase
    end

    assign bus.aref_en     = r_aref_en;
    assign bus.wr_en       = r_wr_en;
    assign bus.rd_en       = r_rd_en;
    assign bus.sdram_cke   = 1'b1;
    assign bus.sdram_cs_n  = w_cmd[3];
    assign bus.sdram_ras_n = w_cmd[2];
    assign bus.sdram_cas_n = w_cmd[1];
    assign bus.sdram_we_n  = w_cmd[0];
    assign bus.sdram_ba    = w_ba;
    assign bus.sdram_addr  = w_addr;

    assign sdram_dq = (r_state == StWrite && bus.wr_sdram_en) ? bus.wr_sdram_data
                                                              : {DATA_W{1'bz}};
    assign bus.rd_sdram_data = sdram_dq;

endmodule
